sipo_loader: RTL and testbench

SIPO_LOADER -- requirements
Module: sipo_loader

---
 rtl/sipo_loader.sv | 85 ++++++++
 tb/tb_sipo_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo_loader.sv
// Serial-in/parallel-out loader: shifts N bits MSB-first, then presents the word on dout with a one-cycle load strobe.
// Optional even-parity check on a trailing bit when SIPO_LOADER_PARITY_EN is defined.
module sipo_loader #(
  parameter int N = 8  // legal range 2..32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sin,
  input  logic         sin_valid,
  output logic [N-1:0] dout,
  output logic         load,
  output logic         busy,
  output logic         par_err
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef SIPO_LOADER_PARITY_EN
  typedef enum logic [2:0] {IDLE, SHIFT, PAR, LOAD, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
`endif

  state_t        state, nxt;
  logic [N-1:0]  sh, sh_nxt;
  logic [CW-1:0] cnt;

  assign sh_nxt = {sh[N-2:0], sin};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (start) nxt = SHIFT;
      SHIFT: if (sin_valid && cnt == LAST) begin
`ifdef SIPO_LOADER_PARITY_EN
        nxt = PAR;
`else
        nxt = LOAD;
`endif
      end
`ifdef SIPO_LOADER_PARITY_EN
      PAR:   if (sin_valid) nxt = ((^sh) ^ sin) ? ERR : LOAD;
      ERR:   nxt = IDLE;
`endif
      LOAD:  nxt = start ? SHIFT : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    load    = (state == LOAD);
`ifdef SIPO_LOADER_PARITY_EN
    par_err = (state == ERR);
`else
    par_err = 1'b0;
`endif
  end

  // dout is captured on the edge entering LOAD so it is valid alongside the strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh   <= '0;
      cnt  <= '0;
      dout <= '0;
    end else begin
      if (state != SHIFT && nxt == SHIFT)
        cnt <= '0;
      else if (state == SHIFT && sin_valid) begin
        sh  <= sh_nxt;
        cnt <= cnt + CW'(1);
      end
      if (nxt == LOAD)
        dout <= (state == SHIFT) ? sh_nxt : sh;
    end
  end

endmodule

// File: tb/tb_sipo_loader.sv
// Scoreboard bench for sipo_loader: frames push expected words, a negedge monitor pops them on each load.
// Parity scenarios run only when SIPO_LOADER_PARITY_EN is defined.
module tb_sipo_loader;
  localparam int N = 8;
`ifdef SIPO_LOADER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic         clk = 1'b0, rst = 1'b0, start = 1'b0, sin = 1'b0, sin_valid = 1'b0;
  logic [N-1:0] dout;
  logic         load, busy, par_err;

  sipo_loader #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .sin(sin), .sin_valid(sin_valid),
    .dout(dout), .load(load), .busy(busy), .par_err(par_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [N-1:0] d; int cyc; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int npass = 0, ntot = 0, cyc = 0, nload = 0;
  logic [N-1:0] prev_dout = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: scoreboard pop on load, exclusivity, dout stability outside load.
  initial forever begin
    @(negedge clk);
    if (!rst) prev_dout = dout;
    else begin
      if (load || par_err) chk("load_perr_excl", {31'b0, load & par_err}, 0);
      if (load) begin
        nload++;
        chk("sb_nonempty", {31'b0, sb.size() > 0}, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("sb_dout", dout, mon_e.d);
          chk("sb_load_edge", cyc, mon_e.cyc);
        end
      end
      if (dout !== prev_dout) chk("dout_only_in_load", load, 1);
      prev_dout = dout;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int edge_no);
    start = 1'b1;
    tick();
    start = 1'b0;
    edge_no = cyc;
  endtask

  // Sends w MSB-first (plus a parity bit when compiled in); optional stall after bit stall_after.
  task automatic send_frame(input logic [N-1:0] w, input int stall_after, input int stall_len,
                            input logic bad_par);
    for (int i = N - 1; i >= 0; i--) begin
      sin = w[i];
      sin_valid = 1'b1;
      if (PB == 0 && i == 0) sb.push_back('{w, cyc + 1});
      tick();
      if (N - i == stall_after) begin
        sin_valid = 1'b0;
        repeat (stall_len) tick();
      end
    end
    if (PB == 1) begin
      sin = (^w) ^ bad_par;
      sin_valid = 1'b1;
      if (!bad_par) sb.push_back('{w, cyc + 1});
      tick();
    end
    sin_valid = 1'b0;
  endtask

  int st, lat1, lat2, l1, nb;

  initial begin
    // reset state
    #2;
    chk("rst_dout", dout, 0);
    chk("rst_load", load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_perr", par_err, 0);
    tick();
    tick();
    rst = 1'b1;

    // sin_valid toggling in IDLE is ignored
    for (int i = 0; i < 6; i++) begin
      sin_valid = i[0];
      sin = 1'($urandom);
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_load", load, 0);
    end
    sin_valid = 1'b0;

    // basic frame A5
    pulse_start(st);
    chk("t1_busy", busy, 1);
    send_frame(8'hA5, 0, 0, 1'b0);
    lat1 = cyc - st;
    chk("t1_lat", lat1, N + PB);
    chk("t1_load", load, 1);
    chk("t1_dout", dout, 8'hA5);
    tick();
    chk("t1_load_1cyc", load, 0);
    chk("t1_busy_after", busy, 0);

    // same frame with a 3-cycle stall after bit 4
    pulse_start(st);
    send_frame(8'hA5, 4, 3, 1'b0);
    lat2 = cyc - st;
    chk("t2_stall_delay", lat2 - lat1, 3);
    chk("t2_load", load, 1);
    chk("t2_dout", dout, 8'hA5);
    tick();

    // back-to-back: start held through LOAD, then 3C
    start = 1'b1;
    tick();
    send_frame(8'h81, 0, 0, 1'b0);
    chk("t3_load1", load, 1);
    chk("t3_dout1", dout, 8'h81);
    l1 = cyc;
    tick();
    start = 1'b0;
    chk("t3_busy_b2b", busy, 1);
    chk("t3_noload", load, 0);
    send_frame(8'h3C, 0, 0, 1'b0);
    chk("t3_gap", cyc - l1, N + 1 + PB);
    chk("t3_load2", load, 1);
    chk("t3_dout2", dout, 8'h3C);
    tick();

    // reset mid-frame after bit 5
    pulse_start(st);
    for (int i = N - 1; i >= N - 5; i--) begin
      sin = i[0];
      sin_valid = 1'b1;
      tick();
    end
    sin_valid = 1'b0;
    nb = nload;
    #2;
    rst = 1'b0;
    #1;
    chk("t4_async_dout", dout, 0);
    chk("t4_async_load", load, 0);
    chk("t4_async_busy", busy, 0);
    chk("t4_async_perr", par_err, 0);
    tick();
    tick();
    chk("t4_no_load", nload, nb);
    rst = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_first_start", busy, 1);
    send_frame(8'hFF, 0, 0, 1'b0);
    chk("t4_load", load, 1);
    chk("t4_dout", dout, 8'hFF);
    tick();

`ifdef SIPO_LOADER_PARITY_EN
    pulse_start(st);
    send_frame(8'hA5, 0, 0, 1'b0);
    chk("p_good_load", load, 1);
    chk("p_good_dout", dout, 8'hA5);
    tick();
    pulse_start(st);
    send_frame(8'hA5, 0, 0, 1'b1);
    chk("p_bad_perr", par_err, 1);
    chk("p_bad_load", load, 0);
    chk("p_bad_dout", dout, 8'hA5);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("p_bad_perr_1cyc", par_err, 0);
    chk("p_err_ignores_start", busy, 0);
    chk("p_bad_dout_hold", dout, 8'hA5);
`endif

    tick();
    tick();
    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
